esfa_port_arbiter: RTL

Round-robin arbiter that shares one ESFADesign instance between up to eight independent requesters, such as ROM-driven benchmark sequencers or host command ports. It accepts one operation per grant over a valid/ready handshake and drives the ESFA operand bus with registered, stable values for a fixed hold window. At the end of the window it samples the ESFA result and returns it to the granted requester as a one-cycle response pulse. It sits between the requesters and the ESFADesign instance and is the only driver of that instance's operand inputs.

---
 rtl/esfa_port_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/esfa_port_arbiter.sv
// Round-robin front end that time-shares one ESFADesign instance among NUM_REQ requesters.
// One operation in flight: accept, hold operands HOLD_CYCLES, sample result, pulse response.
module esfa_port_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned HOLD_CYCLES = 2,
    parameter logic [7:0]  IDLE_SEL    = 8'h00
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [8*NUM_REQ-1:0]   req_handle,
    input  logic [8*NUM_REQ-1:0]   req_index,
    input  logic [8*NUM_REQ-1:0]   req_value,
    input  logic [8*NUM_REQ-1:0]   req_selector,
    output logic [7:0]             esfa_queried_handle,
    output logic [7:0]             esfa_new_index,
    output logic [7:0]             esfa_new_value,
    output logic [7:0]             esfa_selector,
    input  logic                   esfa_result_bool,
    input  logic [7:0]             esfa_result_value,
    output logic                   rsp_valid,
    output logic [2:0]             rsp_id,
    output logic                   rsp_bool,
    output logic [7:0]             rsp_value,
    output logic                   busy,
    output logic [15:0]            op_count
);

    localparam int IDXW = $clog2(NUM_REQ);
    localparam int HCW  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESPOND} state_t;

    state_t          state_q;
    logic [IDXW-1:0] last_grant_q;
    logic [HCW-1:0]  hold_cnt_q;
    logic [7:0]      handle_q, index_q, value_q, sel_q;
    logic            rsp_valid_q, rsp_bool_q, busy_q;
    logic [2:0]      rsp_id_q;
    logic [7:0]      rsp_value_q;
    logic [15:0]     op_count_q;

    logic            grant_vld;
    logic [IDXW-1:0] grant_idx;
    int unsigned     cand;
    logic [7:0]      sel_handle, sel_index, sel_value, sel_selector;

    // Search upward from the requester after the last winner, wrapping at NUM_REQ.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = (32'(last_grant_q) + 32'd1 + k) % NUM_REQ;
            if (!grant_vld && req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = IDXW'(cand);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && grant_vld)
            req_ready[grant_idx] = 1'b1;
    end

    always_comb begin
        sel_handle   = '0;
        sel_index    = '0;
        sel_value    = '0;
        sel_selector = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDXW'(i)) begin
                sel_handle   = req_handle[8*i +: 8];
                sel_index    = req_index[8*i +: 8];
                sel_value    = req_value[8*i +: 8];
                sel_selector = req_selector[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= IDXW'(NUM_REQ - 1);
            hold_cnt_q   <= '0;
            handle_q     <= '0;
            index_q      <= '0;
            value_q      <= '0;
            sel_q        <= IDLE_SEL;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_bool_q   <= 1'b0;
            rsp_value_q  <= '0;
            busy_q       <= 1'b0;
            op_count_q   <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (grant_vld) begin
                        handle_q     <= sel_handle;
                        index_q      <= sel_index;
                        value_q      <= sel_value;
                        sel_q        <= sel_selector;
                        last_grant_q <= grant_idx;
                        hold_cnt_q   <= HCW'(HOLD_CYCLES - 1);
                        busy_q       <= 1'b1;
                        state_q      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (hold_cnt_q == '0) begin
                        // Result is taken at the last edge of the hold window; the bus idles after it.
                        rsp_bool_q  <= esfa_result_bool;
                        rsp_value_q <= esfa_result_value;
                        rsp_id_q    <= 3'(last_grant_q);
                        rsp_valid_q <= 1'b1;
                        handle_q    <= '0;
                        index_q     <= '0;
                        value_q     <= '0;
                        sel_q       <= IDLE_SEL;
                        state_q     <= S_RESPOND;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - 1'b1;
                    end
                end
                S_RESPOND: begin
                    op_count_q <= op_count_q + 16'd1;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign esfa_queried_handle = handle_q;
    assign esfa_new_index      = index_q;
    assign esfa_new_value      = value_q;
    assign esfa_selector       = sel_q;
    assign rsp_valid           = rsp_valid_q;
    assign rsp_id              = rsp_id_q;
    assign rsp_bool            = rsp_bool_q;
    assign rsp_value           = rsp_value_q;
    assign busy                = busy_q;
    assign op_count            = op_count_q;

endmodule
